seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- 8-digit 7-segment dynamic-scan controller.
- Sits directly upstream of the HC595 serial driver and feeds its 16-bit `data` input.
- Takes a 32-bit hex value plus per-digit enable and decimal-point masks, time-multiplexes the digits, and presents {seg, sel} for one digit per scan slot.
- Latches the display value once per frame so a digit never shows mixed old/new data.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SCAN_FREQ, 1000, digit slot rate in Hz. DIV = CLK_FREQ/SCAN_FREQ clocks per slot; DIV must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  display enable; 0 blanks the display and freezes the scan.
- disp_data  in  32  8 hex nibbles; digit i = disp_data[4i+3:4i].
- digit_en  in  8  per-digit enable; bit i=0 blanks digit i.
- dp  in  8  per-digit decimal point; bit i=1 lights the DP of digit i.
- seg  out  8  segment code, active-low; bit7=dp, bits6..0=g..a.
- sel  out  8  digit select, one-hot, active-high; 0 = none.
- out_data  out  16  {seg, sel}, connects to the HC595 driver data input.
- frame_done  out  1  one-cycle pulse when the digit 0 slot starts.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Register values: cnt=0, idx=7, shadow_data=0, shadow_en=0, shadow_dp=0, seg=8'hFF, sel=8'h00, frame_done=0.
  - out_data is 16'hFF00.
  - Reset mid-scan aborts the slot immediately; no partial state survives.
- Slot counter:
  - cnt counts 0..DIV-1 while en=1.
  - tick = en && cnt==DIV-1; on tick cnt←0.
- On tick:
  - idx_next = (idx==7) ? 0 : idx+1; idx←idx_next.
  - seg and sel are registered for idx_next on the same edge, so idx, seg and sel change together.
- Frame latch:
  - On a tick with idx_next==0: shadow_data←disp_data, shadow_en←digit_en, shadow_dp←dp, frame_done←1 for that one cycle.
  - The digit-0 outputs on that edge use the newly sampled inputs, not the old shadow.
  - The first slot after reset is digit 0, DIV cycles after rst_n rises (with en=1).
  - Input changes mid-frame take effect only at the next frame boundary.
- Output for slot i:
  - If shadow_en[i]=0: sel=8'h00, seg=8'hFF.
  - Else: sel=1<<i, seg={~shadow_dp[i], hexcode(nibble i)}.
- hexcode, 7-bit active-low, bits g..a: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, B→03, C→46, D→21, E→06, F→0E.
  - Full seg with dp off: 0→C0, 1→F9, 8→80.
- en=0:
  - Next edge: cnt←0, idx←7, seg←FF, sel←00, frame_done←0. Shadows are held.
  - en rising restarts the sequence exactly as after reset: digit 0 appears DIV cycles later with a fresh latch.
- out_data is a direct concatenation of the registered seg and sel; no added latency.

Test Plan:
- Use CLK_FREQ=1000, SCAN_FREQ=100 (DIV=10) throughout.
- Reset: rst_n=0 for 5 cycles -> out_data=16'hFF00, frame_done=0. Release with en=1, digit_en=FF, dp=00, disp_data=32'h1234_5678 -> after 10 cycles out_data=16'h8001 and frame_done pulses 1 cycle. Then every 10 cycles: F802, 8204, 9208, 9910, B020, A440, F980, then 8001 again with a frame_done pulse.
- Mid-frame update: change disp_data to 32'h8765_4321 while the digit 3 slot is showing -> digits 4..7 still show 4,3,2,1 of the old value; the next frame's digit 0 shows 1 (F901).
- Blanking and DP: digit_en=8'hFE, dp=8'h02 -> digit 0 slot out_data=16'hFF00; digit 1 slot shows "7" with DP lit, seg=78, out_data=16'h7802.
- Enable drop: deassert en during the digit 5 slot -> next edge out_data=FF00, frame_done=0. Reassert after 37 cycles -> first non-blank output exactly 10 cycles later is digit 0.
- Mid-run reset: assert rst_n=0 for 1 cycle during the digit 6 slot -> next edge out_data=FF00. Digit 0 appears 10 cycles after release, with disp_data re-latched.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// 8-digit 7-segment scan controller: one digit per slot, presented as {seg, sel}
// for the HC595 driver, with the display value latched once per frame.
module seg7_scan_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] disp_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  output logic [7:0]  seg,
  output logic [7:0]  sel,
  output logic [15:0] out_data,
  output logic        frame_done
);

  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_data_q, shadow_data_d;
  logic [7:0]    shadow_en_q, shadow_en_d;
  logic [7:0]    shadow_dp_q, shadow_dp_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    sel_q, sel_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          latch;
  logic [2:0]    idx_nxt;
  logic [31:0]   src_data;
  logic [7:0]    src_en;
  logic [7:0]    src_dp;
  logic [3:0]    nib;

  function automatic logic [6:0] hexcode(input logic [3:0] h);
    logic [6:0] c;
    case (h)
      4'h0: c = 7'h40;  4'h1: c = 7'h79;  4'h2: c = 7'h24;  4'h3: c = 7'h30;
      4'h4: c = 7'h19;  4'h5: c = 7'h12;  4'h6: c = 7'h02;  4'h7: c = 7'h78;
      4'h8: c = 7'h00;  4'h9: c = 7'h10;  4'hA: c = 7'h08;  4'hB: c = 7'h03;
      4'hC: c = 7'h46;  4'hD: c = 7'h21;  4'hE: c = 7'h06;  default: c = 7'h0E;
    endcase
    return c;
  endfunction

  always_comb begin
    tick    = en && (cnt_q == CNT_LAST);
    idx_nxt = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
    latch   = tick && (idx_nxt == 3'd0);

    // Digit 0 of a new frame is built from the inputs being latched on this edge
    src_data = latch ? disp_data : shadow_data_q;
    src_en   = latch ? digit_en  : shadow_en_q;
    src_dp   = latch ? dp        : shadow_dp_q;
    nib      = src_data[{idx_nxt, 2'b00} +: 4];

    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_en_d   = shadow_en_q;
    shadow_dp_d   = shadow_dp_q;
    seg_d         = seg_q;
    sel_d         = sel_q;
    frame_done_d  = 1'b0;

    if (!en) begin
      cnt_d = '0;
      idx_d = 3'd7;
      seg_d = 8'hFF;
      sel_d = 8'h00;
    end else begin
      cnt_d        = tick ? '0 : cnt_q + CW'(1);
      frame_done_d = latch;
      if (tick) begin
        idx_d = idx_nxt;
        if (latch) begin
          shadow_data_d = disp_data;
          shadow_en_d   = digit_en;
          shadow_dp_d   = dp;
        end
        if (src_en[idx_nxt]) begin
          sel_d = 8'b1 << idx_nxt;
          seg_d = {~src_dp[idx_nxt], hexcode(nib)};
        end else begin
          sel_d = 8'h00;
          seg_d = 8'hFF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 3'd7;
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= 8'hFF;
      sel_q         <= 8'h00;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign out_data   = {seg_q, sel_q};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed slot sequence plus randomized enable/reset/data
// traffic against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [31:0] disp_data;
  logic [7:0]  digit_en, dp;
  logic [7:0]  seg, sel;
  logic [15:0] out_data;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_ctrl #(.CLK_FREQ(1000), .SCAN_FREQ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .disp_data  (disp_data),
    .digit_en   (digit_en),
    .dp         (dp),
    .seg        (seg),
    .sel        (sel),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model: cycles since the scan (re)started, plus the latched frame
  int          m_run;
  logic [31:0] m_sd;
  logic [7:0]  m_se, m_sp, m_seg, m_sel;
  logic        m_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    if (!rst_n) begin
      m_run = 0; m_sd = '0; m_se = '0; m_sp = '0;
      m_seg = 8'hFF; m_sel = 8'h00; m_fd = 1'b0;
    end else if (!en) begin
      m_run = 0; m_seg = 8'hFF; m_sel = 8'h00; m_fd = 1'b0;
    end else begin
      m_run++;
      m_fd = 1'b0;
      if (m_run % DIV == 0) begin
        d = (m_run / DIV - 1) % 8;
        if (d == 0) begin
          m_sd = disp_data; m_se = digit_en; m_sp = dp; m_fd = 1'b1;
        end
        if (m_se[d]) begin
          m_sel = 8'(1 << d);
          m_seg = {~m_sp[d], hex_tbl[(m_sd >> (4 * d)) & 32'hF]};
        end else begin
          m_sel = 8'h00;
          m_seg = 8'hFF;
        end
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("seg", {24'h0, seg}, {24'h0, m_seg});
      chk("sel", {24'h0, sel}, {24'h0, m_sel});
      chk("out_data", {16'h0, out_data}, {16'h0, m_seg, m_sel});
      chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    end
  endtask

  logic [15:0] seq_exp [8] = '{16'hF802, 16'h8204, 16'h9208, 16'h9910,
                               16'hB020, 16'hA440, 16'hF980, 16'h8001};

  initial begin
    rst_n = 1'b0; en = 1'b0; disp_data = 32'h1234_5678; digit_en = 8'hFF; dp = 8'h00;
    #2;
    step(5);
    chk("reset_out", {16'h0, out_data}, 32'h0000_FF00);
    chk("reset_fd", {31'h0, frame_done}, 32'h0);

    rst_n = 1'b1; en = 1'b1;
    step(10);
    chk("first_digit0", {16'h0, out_data}, 32'h0000_8001);
    chk("first_fd", {31'h0, frame_done}, 32'h1);
    step(1);
    chk("fd_one_cycle", {31'h0, frame_done}, 32'h0);
    step(9);
    for (int i = 0; i < 8; i++) begin
      chk("scan_seq", {16'h0, out_data}, {16'h0, seq_exp[i]});
      step(10);
    end

    // now mid digit-0 slot + 10: advance to digit 3 slot, then change data
    step(20);
    chk("digit3_slot", {24'h0, sel}, 32'h08);
    disp_data = 32'h8765_4321;
    step(5);
    step(10);
    chk("old_digit4", {16'h0, out_data}, 32'h0000_9910);
    step(40);
    chk("new_digit0", {16'h0, out_data}, 32'h0000_F901);

    // blanking and decimal point, restarted via reset
    disp_data = 32'h1234_5678; digit_en = 8'hFE; dp = 8'h02;
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    step(10);
    chk("blank_digit0", {16'h0, out_data}, 32'h0000_FF00);
    chk("blank_fd", {31'h0, frame_done}, 32'h1);
    step(10);
    chk("dp_digit1", {16'h0, out_data}, 32'h0000_7802);

    // enable drop during digit 5, held low 37 cycles
    digit_en = 8'hFF; dp = 8'h00;
    step(45);
    chk("digit5_slot", {24'h0, sel}, 32'h20);
    en = 1'b0; step(1);
    chk("en_drop_out", {16'h0, out_data}, 32'h0000_FF00);
    chk("en_drop_fd", {31'h0, frame_done}, 32'h0);
    step(36);
    en = 1'b1;
    step(9);
    chk("en_restart_blank", {16'h0, out_data}, 32'h0000_FF00);
    step(1);
    chk("en_restart_d0", {16'h0, out_data}, 32'h0000_8001);

    // mid-run reset during digit 6 slot with new data pending
    step(60);
    chk("digit6_slot", {24'h0, sel}, 32'h40);
    disp_data = 32'hCAFE_F00D;
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("rst_mid_out", {16'h0, out_data}, 32'h0000_FF00);
    step(10);
    chk("rst_relatch_d0", {16'h0, out_data}, 32'h0000_A101);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 5) begin
        disp_data = $urandom;
        if ($urandom_range(0, 1) == 1) digit_en = 8'($urandom);
        if ($urandom_range(0, 1) == 1) dp = 8'($urandom);
        en = 1'b1; rst_n = 1'b1;
        step($urandom_range(1, 40));
      end else if (act < 8) begin
        en = 1'b0;
        step($urandom_range(1, 15));
        en = 1'b1;
        step($urandom_range(10, 90));
      end else begin
        rst_n = 1'b0;
        step($urandom_range(1, 3));
        rst_n = 1'b1;
        step($urandom_range(10, 90));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
